// File: rtl/mem_noc_ord_buf.sv
// Memory-bus buffer with multiple requests in flight and responses returned in request order.
// Latency: a request reaches dest one cycle after it is accepted at the earliest; responses go out one cycle after they arrive.
// Backpressure: src_req_ready drops when the request FIFO or order tracker is full; dest_resp_ready drops only when the response FIFO is full.

package mem_noc_pkg;
    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_type_e;

    typedef struct packed {
        mem_type_e   req_type;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } mem_req_t;

    typedef struct packed {
        mem_type_e   resp_type;
        logic [31:0] rdata;
    } mem_resp_t;
endpackage

// Generic FIFO whose pointers carry an extra wrap bit.
// Latency: data pushed in cycle N is visible at head from cycle N+1.
// Backpressure: the caller must not push when full or pop when empty.
module mem_noc_fifo #(
    parameter int DW = 8,
    parameter int DP = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DP);

    if ((DP < 2) || ((DP & (DP - 1)) != 0)) begin : g_dp_check
        $error("mem_noc_fifo: DP must be a power of 2 and at least 2");
    end

    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic [DW-1:0] mem [DP];

    // Read and write pointers wrap modulo 2*DP.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage needs no reset; the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= push_dat;
    end

    assign head  = mem[rptr[AW-1:0]];
    assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign empty = (wptr == rptr);
endmodule

// Ordered memory buffer: request FIFO, response FIFO and an order tracker.
// Latency: at least one cycle from src to dest; local write acks come out one cycle after accept unless an older response is still pending.
// Backpressure: src_req_ready drops when the request FIFO or order tracker is full, with no pass-through on a same-cycle pop.
module mem_noc_ord_buf
    import mem_noc_pkg::*;
#(
    parameter int REQ_DP          = 4,
    parameter int RESP_DP         = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int POSTED_WR       = 1
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 src_req_valid,
    output logic                                 src_req_ready,
    input  mem_req_t                             src_req,
    output logic                                 src_resp_valid,
    input  logic                                 src_resp_ready,
    output mem_resp_t                            src_resp,
    output logic                                 dest_req_valid,
    input  logic                                 dest_req_ready,
    output mem_req_t                             dest_req,
    input  logic                                 dest_resp_valid,
    output logic                                 dest_resp_ready,
    input  mem_resp_t                            dest_resp,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_cnt,
    output logic                                 err_unexp_resp
);
    localparam int OW     = $clog2(MAX_OUTSTANDING + 1);
    localparam bit POSTED = (POSTED_WR != 0);

    logic          req_full, req_empty, req_acc, req_pop;
    logic          ord_full, ord_empty, ord_head_local, ord_pop;
    logic          resp_full, resp_empty, resp_push, resp_pop;
    logic          acc_local, drop_wr, unexp, slv_inc;
    mem_resp_t     resp_head;
    logic [OW-1:0] ord_cnt;
    logic [OW-1:0] slv_pend;

    // Request acceptance; a full buffer never passes a request through.
    assign src_req_ready = ~req_full & ~ord_full;
    assign req_acc       = src_req_valid & src_req_ready;
    assign acc_local     = POSTED && (src_req.req_type == MEM_WRITE);
    assign slv_inc       = req_acc & ~acc_local;

    assign dest_req_valid = ~req_empty;
    assign req_pop        = dest_req_valid & dest_req_ready;

    mem_noc_fifo #(.DW($bits(mem_req_t)), .DP(REQ_DP)) u_req_fifo (
        .clk(clk), .rstn(rstn),
        .push(req_acc), .push_dat(src_req), .pop(req_pop),
        .head(dest_req), .full(req_full), .empty(req_empty)
    );

    // One entry per accepted request: 1 = acked locally, 0 = answered by the slave.
    mem_noc_fifo #(.DW(1), .DP(MAX_OUTSTANDING)) u_ord_fifo (
        .clk(clk), .rstn(rstn),
        .push(req_acc), .push_dat(acc_local), .pop(ord_pop),
        .head(ord_head_local), .full(ord_full), .empty(ord_empty)
    );

    // Posted write responses are swallowed; responses with nothing pending are dropped and flagged.
    assign drop_wr         = POSTED && (dest_resp.resp_type == MEM_WRITE);
    assign unexp           = ~drop_wr && (slv_pend == '0);
    assign dest_resp_ready = drop_wr | unexp | ~resp_full;
    assign resp_push       = dest_resp_valid & ~drop_wr & ~unexp & ~resp_full;

    mem_noc_fifo #(.DW($bits(mem_resp_t)), .DP(RESP_DP)) u_resp_fifo (
        .clk(clk), .rstn(rstn),
        .push(resp_push), .push_dat(dest_resp), .pop(resp_pop),
        .head(resp_head), .full(resp_full), .empty(resp_empty)
    );

    // The master response follows the oldest entry in the order tracker.
    always_comb begin
        src_resp_valid = 1'b0;
        src_resp       = '0;
        if (!ord_empty) begin
            if (ord_head_local) begin
                src_resp_valid     = 1'b1;
                src_resp.resp_type = MEM_WRITE;
            end else begin
                src_resp_valid = ~resp_empty;
                src_resp       = resp_head;
            end
        end
    end

    assign ord_pop  = src_resp_valid & src_resp_ready;
    assign resp_pop = ord_pop & ~ord_head_local;

    // Occupancy and pending-slave counters; increment and decrement together cancel out.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ord_cnt        <= '0;
            slv_pend       <= '0;
            err_unexp_resp <= 1'b0;
        end else begin
            case ({req_acc, ord_pop})
                2'b10:   ord_cnt <= ord_cnt + OW'(1);
                2'b01:   ord_cnt <= ord_cnt - OW'(1);
                default: ord_cnt <= ord_cnt;
            endcase
            case ({slv_inc, resp_push})
                2'b10:   slv_pend <= slv_pend + OW'(1);
                2'b01:   slv_pend <= slv_pend - OW'(1);
                default: slv_pend <= slv_pend;
            endcase
            err_unexp_resp <= dest_resp_valid & unexp;
        end
    end

    assign outstanding_cnt = ord_cnt;
endmodule

// File: tb/tb_mem_noc_ord_buf.sv
// Bench for mem_noc_ord_buf: instance 0 is posted-write, instance 1 is non-posted.
// Expected requests and responses are queued when stimulus is driven and compared on handshake.
// Directed steps cover reset, ordering, full tracker, unexpected response and mid-run reset.
module tb_mem_noc_ord_buf;
    import mem_noc_pkg::*;

    logic      clk = 1'b0;
    logic      rstn = 1'b0;
    logic      src_req_valid   [2];
    logic      src_req_ready   [2];
    mem_req_t  src_req         [2];
    logic      src_resp_valid  [2];
    logic      src_resp_ready  [2];
    mem_resp_t src_resp        [2];
    logic      dest_req_valid  [2];
    logic      dest_req_ready  [2];
    mem_req_t  dest_req        [2];
    logic      dest_resp_valid [2];
    logic      dest_resp_ready [2];
    mem_resp_t dest_resp       [2];
    logic [2:0] outstanding_cnt[2];
    logic      err_unexp_resp  [2];

    int checks   = 0;
    int failures = 0;
    mem_resp_t exp_resp_q[$];
    mem_req_t  exp_req_q[$];

    always #5 clk = ~clk;

    mem_noc_ord_buf #(.REQ_DP(4), .RESP_DP(4), .MAX_OUTSTANDING(4), .POSTED_WR(1)) u_post (
        .clk(clk), .rstn(rstn),
        .src_req_valid(src_req_valid[0]), .src_req_ready(src_req_ready[0]), .src_req(src_req[0]),
        .src_resp_valid(src_resp_valid[0]), .src_resp_ready(src_resp_ready[0]), .src_resp(src_resp[0]),
        .dest_req_valid(dest_req_valid[0]), .dest_req_ready(dest_req_ready[0]), .dest_req(dest_req[0]),
        .dest_resp_valid(dest_resp_valid[0]), .dest_resp_ready(dest_resp_ready[0]), .dest_resp(dest_resp[0]),
        .outstanding_cnt(outstanding_cnt[0]), .err_unexp_resp(err_unexp_resp[0])
    );

    mem_noc_ord_buf #(.REQ_DP(4), .RESP_DP(4), .MAX_OUTSTANDING(4), .POSTED_WR(0)) u_np (
        .clk(clk), .rstn(rstn),
        .src_req_valid(src_req_valid[1]), .src_req_ready(src_req_ready[1]), .src_req(src_req[1]),
        .src_resp_valid(src_resp_valid[1]), .src_resp_ready(src_resp_ready[1]), .src_resp(src_resp[1]),
        .dest_req_valid(dest_req_valid[1]), .dest_req_ready(dest_req_ready[1]), .dest_req(dest_req[1]),
        .dest_resp_valid(dest_resp_valid[1]), .dest_resp_ready(dest_resp_ready[1]), .dest_resp(dest_resp[1]),
        .outstanding_cnt(outstanding_cnt[1]), .err_unexp_resp(err_unexp_resp[1])
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare every handshake against the oldest queued expectation.
    always @(negedge clk) begin
        mem_resp_t er;
        mem_req_t  eq;
        for (int u = 0; u < 2; u++) begin
            if (rstn && src_resp_valid[u] && src_resp_ready[u]) begin
                if (exp_resp_q.size() == 0) begin
                    chk("src_resp_unexpected_valid", 128'(src_resp_valid[u]), 128'(0));
                end else begin
                    er = exp_resp_q.pop_front();
                    chk("src_resp", 128'(src_resp[u]), 128'(er));
                end
            end
            if (rstn && dest_req_valid[u] && dest_req_ready[u]) begin
                if (exp_req_q.size() == 0) begin
                    chk("dest_req_unexpected_valid", 128'(dest_req_valid[u]), 128'(0));
                end else begin
                    eq = exp_req_q.pop_front();
                    chk("dest_req", 128'(dest_req[u]), 128'(eq));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench did not finish");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input int u, input mem_type_e t, input logic [31:0] a,
                            input logic [31:0] d, input bit track, input mem_resp_t er);
        mem_req_t r;
        logic acc;
        acc = 1'b0;
        r = '{req_type: t, addr: a, wdata: d, be: 4'hf};
        if (track) begin
            exp_req_q.push_back(r);
            exp_resp_q.push_back(er);
        end
        src_req[u] = r;
        src_req_valid[u] = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            acc = src_req_ready[u];
            tick();
            if (acc) break;
        end
        src_req_valid[u] = 1'b0;
        if (!acc) chk("src_req_accept_timeout", 128'(acc), 128'(1));
    endtask

    task automatic slave_resp(input int u, input mem_type_e t, input logic [31:0] d,
                              output logic err_seen);
        logic rdy;
        rdy = 1'b0;
        dest_resp[u] = '{resp_type: t, rdata: d};
        dest_resp_valid[u] = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            rdy = dest_resp_ready[u];
            tick();
            if (rdy) break;
        end
        dest_resp_valid[u] = 1'b0;
        err_seen = err_unexp_resp[u];
        if (!rdy) chk("dest_resp_accept_timeout", 128'(rdy), 128'(1));
    endtask

    task automatic wait_drain(input int u, input string tag);
        for (int i = 0; i < 100; i++) begin
            if (outstanding_cnt[u] == 3'd0 && exp_resp_q.size() == 0) break;
            tick();
        end
        chk(tag, 128'(outstanding_cnt[u]), 128'(0));
        chk({tag, "_resp_left"}, 128'(exp_resp_q.size()), 128'(0));
    endtask

    initial begin
        logic e;
        mem_resp_t wr_ack;
        wr_ack = '{resp_type: MEM_WRITE, rdata: 32'h0};
        for (int u = 0; u < 2; u++) begin
            src_req_valid[u] = 1'b0;
            src_req[u] = '0;
            src_resp_ready[u] = 1'b1;
            dest_req_ready[u] = 1'b1;
            dest_resp_valid[u] = 1'b0;
            dest_resp[u] = '0;
        end

        // Values while reset is held.
        #12;
        for (int u = 0; u < 2; u++) begin
            chk("rst_src_req_ready", 128'(src_req_ready[u]), 128'(1));
            chk("rst_dest_resp_ready", 128'(dest_resp_ready[u]), 128'(1));
            chk("rst_src_resp_valid", 128'(src_resp_valid[u]), 128'(0));
            chk("rst_dest_req_valid", 128'(dest_req_valid[u]), 128'(0));
            chk("rst_outstanding", 128'(outstanding_cnt[u]), 128'(0));
            chk("rst_err", 128'(err_unexp_resp[u]), 128'(0));
        end
        @(negedge clk);
        rstn = 1'b1;
        tick();
        tick();
        chk("idle_src_req_ready", 128'(src_req_ready[0]), 128'(1));
        chk("idle_outstanding", 128'(outstanding_cnt[0]), 128'(0));

        // Three posted writes back to back, acked locally in order.
        for (int i = 0; i < 3; i++)
            send_req(0, MEM_WRITE, 32'h100 + 32'(i), 32'hA0 + 32'(i), 1'b1, wr_ack);
        for (int i = 0; i < 3; i++) begin
            slave_resp(0, MEM_WRITE, 32'hDEAD, e);
            chk("posted_wr_drop_err", 128'(e), 128'(0));
        end
        wait_drain(0, "posted_wr_drain");

        // Four reads fill the tracker; slave answers arrive later.
        for (int i = 0; i < 4; i++)
            send_req(0, MEM_READ, 32'h200 + 32'(4 * i), 32'h0, 1'b1,
                     '{resp_type: MEM_READ, rdata: 32'h11 * 32'(i + 1)});
        chk("full_src_req_ready", 128'(src_req_ready[0]), 128'(0));
        chk("full_outstanding", 128'(outstanding_cnt[0]), 128'(4));
        for (int i = 0; i < 4; i++) begin
            slave_resp(0, MEM_READ, 32'h11 * 32'(i + 1), e);
            chk("read_resp_err", 128'(e), 128'(0));
        end
        wait_drain(0, "read4_drain");

        // A local write ack stays behind an older read.
        send_req(0, MEM_READ, 32'h300, 32'h0, 1'b1, '{resp_type: MEM_READ, rdata: 32'h55});
        send_req(0, MEM_WRITE, 32'h304, 32'h77, 1'b1, wr_ack);
        repeat (10) tick();
        chk("ack_withheld_valid", 128'(src_resp_valid[0]), 128'(0));
        chk("ack_withheld_outstanding", 128'(outstanding_cnt[0]), 128'(2));
        slave_resp(0, MEM_READ, 32'h55, e);
        slave_resp(0, MEM_WRITE, 32'hBEEF, e);
        chk("late_wr_drop_err", 128'(e), 128'(0));
        wait_drain(0, "rd_wr_drain");

        // Response with nothing pending is dropped and flagged for one cycle.
        chk("unexp_ready", 128'(dest_resp_ready[0]), 128'(1));
        slave_resp(0, MEM_READ, 32'h99, e);
        chk("unexp_err_pulse", 128'(e), 128'(1));
        tick();
        chk("unexp_err_clear", 128'(err_unexp_resp[0]), 128'(0));
        chk("unexp_outstanding", 128'(outstanding_cnt[0]), 128'(0));

        // Reset with two reads in flight discards everything immediately.
        dest_req_ready[0] = 1'b0;
        send_req(0, MEM_READ, 32'h400, 32'h0, 1'b0, wr_ack);
        send_req(0, MEM_READ, 32'h404, 32'h0, 1'b0, wr_ack);
        chk("pre_rst_outstanding", 128'(outstanding_cnt[0]), 128'(2));
        chk("pre_rst_dest_req_valid", 128'(dest_req_valid[0]), 128'(1));
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_outstanding", 128'(outstanding_cnt[0]), 128'(0));
        chk("mid_rst_src_req_ready", 128'(src_req_ready[0]), 128'(1));
        chk("mid_rst_dest_req_valid", 128'(dest_req_valid[0]), 128'(0));
        chk("mid_rst_src_resp_valid", 128'(src_resp_valid[0]), 128'(0));
        @(negedge clk);
        rstn = 1'b1;
        dest_req_ready[0] = 1'b1;
        tick();
        tick();
        chk("post_rst_dest_req_valid", 128'(dest_req_valid[0]), 128'(0));

        // Non-posted: slave write and read responses both forwarded in order.
        send_req(1, MEM_WRITE, 32'h500, 32'h1234, 1'b1, '{resp_type: MEM_WRITE, rdata: 32'hA1});
        send_req(1, MEM_READ, 32'h504, 32'h0, 1'b1, '{resp_type: MEM_READ, rdata: 32'hB2});
        repeat (3) tick();
        chk("np_no_local_ack", 128'(src_resp_valid[1]), 128'(0));
        chk("np_outstanding", 128'(outstanding_cnt[1]), 128'(2));
        slave_resp(1, MEM_WRITE, 32'hA1, e);
        chk("np_wr_err", 128'(e), 128'(0));
        slave_resp(1, MEM_READ, 32'hB2, e);
        chk("np_rd_err", 128'(e), 128'(0));
        wait_drain(1, "np_drain");
        chk("dest_req_left", 128'(exp_req_q.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
